// File: rtl/mnist_mlp_argmax.sv
// Serial argmax over one packed score vector from the mnist_mlp output channel.
// Returns the winning class index and score on a valid/ready channel and counts handoffs.
module mnist_mlp_argmax #(
  parameter int N_CLASSES = 10,
  parameter int SCORE_W   = 18,
  parameter int IDX_W     = 4,
  parameter int CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_CLASSES*SCORE_W-1:0]   output1_rsc_dat,
  input  logic                           output1_rsc_vld,
  output logic                           output1_rsc_rdy,
  output logic [IDX_W-1:0]               class_idx,
  output logic [SCORE_W-1:0]             class_score,
  output logic                           class_vld,
  input  logic                           class_rdy,
  output logic [CNT_W-1:0]               class_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                state_r;
  logic signed [SCORE_W-1:0] scores_r [N_CLASSES];
  logic [IDX_W-1:0]          ptr_r;
  logic [IDX_W-1:0]          best_idx_r;
  logic signed [SCORE_W-1:0] best_r;
  logic                      rdy_r;
  logic                      vld_r;
  logic [CNT_W-1:0]          cnt_r;

  logic signed [SCORE_W-1:0] cand_s;
  logic                      cand_gt_s;
  logic                      last_s;
  logic                      accept_s;
  logic                      handoff_s;

  // Candidate selection and handshake decode; strict compare keeps the lowest index on ties.
  always_comb begin
    cand_s    = scores_r[ptr_r];
    cand_gt_s = (cand_s > best_r);
    last_s    = (ptr_r == IDX_W'(N_CLASSES - 1));
    accept_s  = output1_rsc_vld & rdy_r;
    handoff_s = vld_r & class_rdy;
  end

  // Scan FSM, result registers and handoff counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= IDX_W'(0);
      best_idx_r <= IDX_W'(0);
      best_r     <= SCORE_W'(0);
      rdy_r      <= 1'b1;
      vld_r      <= 1'b0;
      cnt_r      <= CNT_W'(0);
      for (int i = 0; i < N_CLASSES; i++) begin
        scores_r[i] <= SCORE_W'(0);
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            for (int i = 0; i < N_CLASSES; i++) begin
              scores_r[i] <= output1_rsc_dat[i*SCORE_W +: SCORE_W];
            end
            best_r     <= output1_rsc_dat[SCORE_W-1:0];
            best_idx_r <= IDX_W'(0);
            ptr_r      <= IDX_W'(1);
            rdy_r      <= 1'b0;
            if (N_CLASSES == 1) begin
              state_r <= DONE;
              vld_r   <= 1'b1;
            end else begin
              state_r <= SCAN;
            end
          end
        end
        SCAN: begin
          if (cand_gt_s) begin
            best_r     <= cand_s;
            best_idx_r <= ptr_r;
          end
          ptr_r <= ptr_r + IDX_W'(1);
          if (last_s) begin
            state_r <= DONE;
            vld_r   <= 1'b1;
          end
        end
        DONE: begin
          // Result registers stay frozen here until the downstream takes them.
          if (handoff_s) begin
            vld_r   <= 1'b0;
            rdy_r   <= 1'b1;
            cnt_r   <= cnt_r + CNT_W'(1);
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          rdy_r   <= 1'b1;
          vld_r   <= 1'b0;
        end
      endcase
    end
  end

  assign output1_rsc_rdy = rdy_r;
  assign class_vld       = vld_r;
  assign class_idx       = best_idx_r;
  assign class_score     = best_r;
  assign class_cnt       = cnt_r;

endmodule

// File: tb/tb_mnist_mlp_argmax.sv
// Scoreboard bench for mnist_mlp_argmax: driver pushes expected results, a monitor pops on handoff.
// A narrow counter is used so counter wrap is reached in a short run.
module tb_mnist_mlp_argmax;

  localparam int N  = 10;
  localparam int SW = 18;
  localparam int IW = 4;
  localparam int CW = 5;
  localparam int DW = N * SW;

  logic          clk;
  logic          rst;
  logic [DW-1:0] output1_rsc_dat;
  logic          output1_rsc_vld;
  logic          output1_rsc_rdy;
  logic [IW-1:0] class_idx;
  logic [SW-1:0] class_score;
  logic          class_vld;
  logic          class_rdy;
  logic [CW-1:0] class_cnt;

  mnist_mlp_argmax #(.N_CLASSES(N), .SCORE_W(SW), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .output1_rsc_dat (output1_rsc_dat),
    .output1_rsc_vld (output1_rsc_vld),
    .output1_rsc_rdy (output1_rsc_rdy),
    .class_idx       (class_idx),
    .class_score     (class_score),
    .class_vld       (class_vld),
    .class_rdy       (class_rdy),
    .class_cnt       (class_cnt)
  );

  typedef struct {
    int            idx;
    int            score;
    int            acc;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  logic          vld_prev = 1'b0;
  logic [CW-1:0] exp_cnt = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] fill(input int s);
    logic [DW-1:0] v;
    logic [SW-1:0] t;
    t = SW'(s);
    for (int i = 0; i < N; i++) v[i*SW +: SW] = t;
    return v;
  endfunction

  function automatic logic [DW-1:0] put(input logic [DW-1:0] v, input int i, input int s);
    logic [SW-1:0] t;
    t = SW'(s);
    v[i*SW +: SW] = t;
    return v;
  endfunction

  // Reference argmax: first strictly greater signed score wins.
  function automatic void ref_argmax(input logic [DW-1:0] v, output int bi, output int bs);
    logic signed [SW-1:0] s;
    bi = 0;
    s  = v[SW-1:0];
    bs = int'(s);
    for (int i = 1; i < N; i++) begin
      s = v[i*SW +: SW];
      if (int'(s) > bs) begin
        bs = int'(s);
        bi = i;
      end
    end
  endfunction

  task automatic send(input logic [DW-1:0] d, input int eidx, input int escore, output int waits);
    exp_t e;
    output1_rsc_dat = d;
    output1_rsc_vld = 1'b1;
    waits = 0;
    while (!output1_rsc_rdy && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (output1_rsc_rdy) begin
      e.idx   = eidx;
      e.score = escore;
      e.acc   = cyc;
      e.cnt   = exp_cnt;
      exp_cnt = exp_cnt + CW'(1);
      sb_q.push_back(e);
    end else begin
      total++;
      bad++;
      $display("FAIL accept_timeout: rdy stayed %0b expected 1", output1_rsc_rdy);
    end
    @(negedge clk);
    output1_rsc_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb_q.size(), 0);
  endtask

  // Monitor: compares presented results against the scoreboard head, pops on handoff.
  always @(negedge clk) begin
    #1;
    if (!rst && class_vld) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_vld: got class_vld=1 idx=%0d expected no result", class_idx);
      end else begin
        mon_e = sb_q[0];
        if (!vld_prev) chk("latency", cyc - mon_e.acc, N);
        chk("class_idx", int'(class_idx), mon_e.idx);
        chk("class_score", int'($signed(class_score)), mon_e.score);
        chk("in_rdy_low_in_done", int'(output1_rsc_rdy), 0);
        if (class_rdy) begin
          chk("class_cnt_at_handoff", int'(class_cnt), int'(mon_e.cnt));
          void'(sb_q.pop_front());
        end
      end
    end
    vld_prev = class_vld;
  end

  initial begin
    logic [DW-1:0] v;
    int w, n, ei, es;

    rst = 1'b1;
    output1_rsc_dat = '0;
    output1_rsc_vld = 1'b0;
    class_rdy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_rdy", int'(output1_rsc_rdy), 1);
    chk("rst_class_vld", int'(class_vld), 0);
    chk("rst_class_idx", int'(class_idx), 0);
    chk("rst_class_score", int'(class_score), 0);
    chk("rst_class_cnt", int'(class_cnt), 0);

    // Ascending scores: last index wins.
    v = '0;
    for (int i = 0; i < N; i++) v = put(v, i, i);
    send(v, 9, 9, w);
    drain();
    chk("cnt_after_first", int'(class_cnt), 1);

    // Tie between 3 and 7: lowest index wins.
    v = put(put(fill(-1), 3, 100), 7, 100);
    send(v, 3, 100, w);
    // All negative: signed compare.
    v = put(fill(-1000), 5, -2);
    send(v, 5, -2, w);
    drain();

    // Downstream stall with a second vector waiting.
    class_rdy = 1'b0;
    v = put(fill(0), 6, 500);
    send(v, 6, 500, w);
    n = 0;
    while (!class_vld && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("stall_vld_seen", int'(class_vld), 1);
    output1_rsc_dat = put(fill(-9), 2, -5);
    output1_rsc_vld = 1'b1;
    repeat (20) @(negedge clk);
    chk("stall_in_rdy", int'(output1_rsc_rdy), 0);
    chk("stall_vld_held", int'(class_vld), 1);
    class_rdy = 1'b1;
    send(put(fill(-9), 2, -5), 2, -5, w);
    chk("second_accept_wait", w, 1);
    drain();

    // Reset in the middle of a scan discards the result.
    send(fill(3), 0, 3, w);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("midscan_rst_in_rdy", int'(output1_rsc_rdy), 1);
    chk("midscan_rst_vld", int'(class_vld), 0);
    chk("midscan_rst_cnt", int'(class_cnt), 0);
    @(negedge clk);
    chk("after_rst_in_rdy", int'(output1_rsc_rdy), 1);
    send(put(fill(1), 0, 77), 0, 77, w);
    drain();
    chk("cnt_after_rst", int'(class_cnt), 1);

    // Back-to-back vectors through counter wrap.
    for (int k = 0; k < 35; k++) begin
      v = '0;
      for (int i = 0; i < N; i++) v = put(v, i, ((k * 7 + i * 13) % 23) - 11);
      if (k % 4 == 1) v = put(v, 8, 131071);
      if (k % 4 == 2) v = put(v, 4, -131072);
      ref_argmax(v, ei, es);
      send(v, ei, es, w);
      if (k > 0) chk("b2b_spacing", w, N);
    end
    drain();
    chk("cnt_wrapped", int'(class_cnt), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
